// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and BCD helpers for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_e;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;

  // Increment a two-digit BCD value, wrapping to 00 after max (binary).
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd, input int unsigned max);
    logic [3:0]  tens;
    logic [3:0]  ones;
    int unsigned val;
    tens = bcd[7:4];
    ones = bcd[3:0];
    val  = 32'(tens) * 10 + 32'(ones);
    if (val >= max)         return '0;
    else if (ones == 4'd9)  return {tens + 4'd1, 4'd0};
    else                    return {tens, ones + 4'd1};
  endfunction

  // Convert a binary 0..99 value to two BCD digits.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/alarm_if.sv
// Signal bundle between the clock/button front end and the alarm controller.
interface alarm_if;
  logic       tick_1Hz;
  logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
  logic       set_alarm, alarm_en;
  logic       btn_hr, btn_min, btn_snooze, btn_stop;
  logic [3:0] alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s;
  logic       ringing, snoozing, buzzer;
  logic [1:0] state;

  modport master (
    output tick_1Hz, hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
           set_alarm, alarm_en, btn_hr, btn_min, btn_snooze, btn_stop,
    input  alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
           ringing, snoozing, buzzer, state
  );

  modport slave (
    input  tick_1Hz, hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
           set_alarm, alarm_en, btn_hr, btn_min, btn_snooze, btn_stop,
    output alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
           ringing, snoozing, buzzer, state
  );
endinterface

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;

  // Synchronize the raw input and emit a one-cycle pulse on its rising edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: stores the BCD alarm time, detects the match and runs the
// ring/snooze state machine with its second counters.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned ALARM_HR_INIT  = 7,
  parameter int unsigned ALARM_MIN_INIT = 0
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  input  logic       set_alarm,
  input  logic       alarm_en,
  input  logic       btn_hr,
  input  logic       btn_min,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic [3:0] alarm_hr_10s,
  output logic [3:0] alarm_hr_1s,
  output logic [3:0] alarm_min_10s,
  output logic [3:0] alarm_min_1s,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam int unsigned RW = $clog2(RING_SECONDS + 1);
  localparam int unsigned SW = $clog2(SNOOZE_MINUTES * 60 + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MINUTES * 60);
  localparam logic [7:0] HR_INIT_BCD  = to_bcd(ALARM_HR_INIT);
  localparam logic [7:0] MIN_INIT_BCD = to_bcd(ALARM_MIN_INIT);

  logic sec_p, hr_p, min_p, snz_p, stop_p;

  edge_sync u_sync_sec  (.clk_i(clk_100MHz), .rst_ni(reset), .d_i(tick_1Hz),   .pulse_o(sec_p));
  edge_sync u_sync_hr   (.clk_i(clk_100MHz), .rst_ni(reset), .d_i(btn_hr),     .pulse_o(hr_p));
  edge_sync u_sync_min  (.clk_i(clk_100MHz), .rst_ni(reset), .d_i(btn_min),    .pulse_o(min_p));
  edge_sync u_sync_snz  (.clk_i(clk_100MHz), .rst_ni(reset), .d_i(btn_snooze), .pulse_o(snz_p));
  edge_sync u_sync_stop (.clk_i(clk_100MHz), .rst_ni(reset), .d_i(btn_stop),   .pulse_o(stop_p));

  logic [7:0]    alarm_hr_q, alarm_hr_d, alarm_min_q, alarm_min_d;
  state_e        state_q, state_d;
  logic [RW-1:0] ring_ctr_q, ring_ctr_d;
  logic [SW-1:0] snz_ctr_q, snz_ctr_d;
  logic          beep_q, beep_d;
  logic          ringing_q, snoozing_q, buzzer_q;
  logic          match;

  // Alarm time adjust in set mode; hour and minute wrap independently.
  always_comb begin
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    if (set_alarm) begin
      if (hr_p)  alarm_hr_d  = bcd_inc(alarm_hr_q, HR_MAX);
      if (min_p) alarm_min_d = bcd_inc(alarm_min_q, MIN_MAX);
    end
  end

  assign match = sec_p && !set_alarm &&
                 ({hr_10s, hr_1s} == alarm_hr_q) &&
                 ({min_10s, min_1s} == alarm_min_q) &&
                 (sec_10s == 4'd0) && (sec_1s == 4'd0);

  // Next-state logic; priority is alarm_en, set_alarm, stop, snooze, timers.
  always_comb begin
    state_d    = state_q;
    ring_ctr_d = ring_ctr_q;
    snz_ctr_d  = snz_ctr_q;
    beep_d     = beep_q;
    if (!alarm_en) begin
      state_d    = ST_IDLE;
      ring_ctr_d = '0;
      snz_ctr_d  = '0;
      beep_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_d    = ST_RINGING;
            ring_ctr_d = '0;
            beep_d     = 1'b1;
          end
        end
        ST_RINGING: begin
          if (set_alarm || stop_p) begin
            state_d = ST_ARMED;
          end else if (snz_p) begin
            state_d   = ST_SNOOZE;
            snz_ctr_d = SNZ_LOAD;
          end else if (sec_p) begin
            if (ring_ctr_q >= RING_LAST) begin
              state_d = ST_ARMED;
            end else begin
              ring_ctr_d = ring_ctr_q + RW'(1);
              beep_d     = ~beep_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (set_alarm || stop_p) begin
            state_d = ST_ARMED;
          end else if (sec_p) begin
            if (snz_ctr_q <= SW'(1)) begin
              snz_ctr_d  = '0;
              state_d    = ST_RINGING;
              ring_ctr_d = '0;
              beep_d     = 1'b1;
            end else begin
              snz_ctr_d = snz_ctr_q - SW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters, alarm digits and output decodes (taken from next state
  // so the outputs change in the same cycle as the state register).
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ring_ctr_q  <= '0;
      snz_ctr_q   <= '0;
      beep_q      <= 1'b0;
      ringing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
      buzzer_q    <= 1'b0;
      alarm_hr_q  <= HR_INIT_BCD;
      alarm_min_q <= MIN_INIT_BCD;
    end else begin
      state_q     <= state_d;
      ring_ctr_q  <= ring_ctr_d;
      snz_ctr_q   <= snz_ctr_d;
      beep_q      <= beep_d;
      ringing_q   <= (state_d == ST_RINGING);
      snoozing_q  <= (state_d == ST_SNOOZE);
      buzzer_q    <= (state_d == ST_RINGING) & beep_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
    end
  end

  assign alarm_hr_10s  = alarm_hr_q[7:4];
  assign alarm_hr_1s   = alarm_hr_q[3:0];
  assign alarm_min_10s = alarm_min_q[7:4];
  assign alarm_min_1s  = alarm_min_q[3:0];
  assign ringing       = ringing_q;
  assign snoozing      = snoozing_q;
  assign buzzer        = buzzer_q;
  assign state         = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed, table-driven bench for alarm_controller.
module tb_alarm_controller;
  logic clk;
  logic rst_n;
  alarm_if bus ();

  int tests = 0;
  int fails = 0;

  alarm_controller #(
    .RING_SECONDS   (60),
    .SNOOZE_MINUTES (5),
    .ALARM_HR_INIT  (7),
    .ALARM_MIN_INIT (0)
  ) dut (
    .clk_100MHz    (clk),
    .reset         (rst_n),
    .tick_1Hz      (bus.tick_1Hz),
    .hr_10s        (bus.hr_10s),
    .hr_1s         (bus.hr_1s),
    .min_10s       (bus.min_10s),
    .min_1s        (bus.min_1s),
    .sec_10s       (bus.sec_10s),
    .sec_1s        (bus.sec_1s),
    .set_alarm     (bus.set_alarm),
    .alarm_en      (bus.alarm_en),
    .btn_hr        (bus.btn_hr),
    .btn_min       (bus.btn_min),
    .btn_snooze    (bus.btn_snooze),
    .btn_stop      (bus.btn_stop),
    .alarm_hr_10s  (bus.alarm_hr_10s),
    .alarm_hr_1s   (bus.alarm_hr_1s),
    .alarm_min_10s (bus.alarm_min_10s),
    .alarm_min_1s  (bus.alarm_min_1s),
    .ringing       (bus.ringing),
    .snoozing      (bus.snoozing),
    .buzzer        (bus.buzzer),
    .state         (bus.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n_hr;
    int unsigned n_min;
    int unsigned n_both;
    logic [15:0] exp_alarm;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int alarm_word();
    return int'({bus.alarm_hr_10s, bus.alarm_hr_1s, bus.alarm_min_10s, bus.alarm_min_1s});
  endfunction

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.hr_10s  = h[7:4];
    bus.hr_1s   = h[3:0];
    bus.min_10s = m[7:4];
    bus.min_1s  = m[3:0];
    bus.sec_10s = s[7:4];
    bus.sec_1s  = s[3:0];
  endtask

  task automatic press(input logic hr, input logic mn, input logic snz, input logic stp);
    bus.btn_hr = hr; bus.btn_min = mn; bus.btn_snooze = snz; bus.btn_stop = stp;
    repeat (4) @(negedge clk);
    bus.btn_hr = 1'b0; bus.btn_min = 1'b0; bus.btn_snooze = 1'b0; bus.btn_stop = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick();
    bus.tick_1Hz = 1'b1;
    repeat (4) @(negedge clk);
    bus.tick_1Hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Drive a 07:00:00 match, checking pulse latency, then move the clock on.
  task automatic start_ring(input string tag);
    set_time(8'h07, 8'h00, 8'h00);
    bus.tick_1Hz = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_ring_early"}, int'(bus.ringing), 0);
    @(negedge clk);
    check({tag, "_ring_start"}, int'(bus.ringing), 1);
    check({tag, "_buzz_start"}, int'(bus.buzzer), 1);
    bus.tick_1Hz = 1'b0;
    repeat (4) @(negedge clk);
    set_time(8'h07, 8'h00, 8'h01);
  endtask

  initial begin
    vecs[0] = '{n_hr: 0,  n_min: 3,  n_both: 0, exp_alarm: 16'h0703};
    vecs[1] = '{n_hr: 18, n_min: 0,  n_both: 0, exp_alarm: 16'h0103};
    vecs[2] = '{n_hr: 0,  n_min: 56, n_both: 0, exp_alarm: 16'h0159};
    vecs[3] = '{n_hr: 0,  n_min: 1,  n_both: 0, exp_alarm: 16'h0100};
    vecs[4] = '{n_hr: 9,  n_min: 0,  n_both: 0, exp_alarm: 16'h1000};
    vecs[5] = '{n_hr: 0,  n_min: 0,  n_both: 2, exp_alarm: 16'h1202};
    vecs[6] = '{n_hr: 19, n_min: 58, n_both: 0, exp_alarm: 16'h0700};

    rst_n = 1'b0;
    bus.tick_1Hz = 1'b0;
    set_time(8'h00, 8'h00, 8'h00);
    bus.set_alarm = 1'b0; bus.alarm_en = 1'b0;
    bus.btn_hr = 1'b0; bus.btn_min = 1'b0; bus.btn_snooze = 1'b0; bus.btn_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state",    int'(bus.state), 0);
    check("rst_ringing",  int'(bus.ringing), 0);
    check("rst_snoozing", int'(bus.snoozing), 0);
    check("rst_buzzer",   int'(bus.buzzer), 0);
    check("rst_alarm",    alarm_word(), 16'h0700);

    rst_n = 1'b1;
    bus.alarm_en = 1'b1;
    bus.set_alarm = 1'b1;
    repeat (2) @(negedge clk);
    check("armed_after_en", int'(bus.state), 1);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < int'(vecs[i].n_hr); k++)   press(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < int'(vecs[i].n_min); k++)  press(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < int'(vecs[i].n_both); k++) press(1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("set_vec%0d", i), alarm_word(), int'(vecs[i].exp_alarm));
    end

    bus.set_alarm = 1'b0;
    press(1'b1, 1'b1, 1'b0, 1'b0);
    check("no_set_outside_mode", alarm_word(), 16'h0700);

    set_time(8'h06, 8'h59, 8'h59);
    tick();
    check("no_ring_0659", int'(bus.ringing), 0);
    check("armed_0659", int'(bus.state), 1);

    // Automatic ring timeout with buzzer cadence.
    start_ring("auto");
    for (int k = 1; k <= 59; k++) begin
      tick();
      if (k <= 3) check($sformatf("buzz_tick%0d", k), int'(bus.buzzer), (k % 2 == 0) ? 1 : 0);
    end
    check("ring_at_59", int'(bus.ringing), 1);
    tick();
    check("ring_end", int'(bus.ringing), 0);
    check("ring_end_state", int'(bus.state), 1);
    check("ring_end_buzz", int'(bus.buzzer), 0);

    // Snooze expiry and stop during snooze.
    start_ring("snz");
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("snooze_on", int'(bus.snoozing), 1);
    check("snooze_state", int'(bus.state), 3);
    check("snooze_quiet", int'(bus.ringing), 0);
    for (int k = 1; k <= 299; k++) tick();
    check("snooze_299", int'(bus.snoozing), 1);
    tick();
    check("snooze_rering", int'(bus.ringing), 1);
    check("snooze_rebuzz", int'(bus.buzzer), 1);
    check("snooze_off", int'(bus.snoozing), 0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("snooze_again", int'(bus.snoozing), 1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("stop_in_snooze", int'(bus.state), 1);
    check("stop_in_snooze_snz", int'(bus.snoozing), 0);

    // Stop and snooze together: stop wins.
    start_ring("both");
    press(1'b0, 1'b0, 1'b1, 1'b1);
    check("both_state", int'(bus.state), 1);
    check("both_snoozing", int'(bus.snoozing), 0);
    check("both_ringing", int'(bus.ringing), 0);

    // Disable while ringing.
    start_ring("dis");
    bus.alarm_en = 1'b0;
    @(negedge clk);
    check("dis_state", int'(bus.state), 0);
    check("dis_buzzer", int'(bus.buzzer), 0);
    check("dis_ringing", int'(bus.ringing), 0);
    bus.alarm_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reen_state", int'(bus.state), 1);

    // Match while in set mode does not ring.
    bus.set_alarm = 1'b1;
    set_time(8'h07, 8'h00, 8'h00);
    tick();
    check("set_mode_no_ring", int'(bus.ringing), 0);
    check("set_mode_armed", int'(bus.state), 1);
    bus.set_alarm = 1'b0;
    set_time(8'h07, 8'h00, 8'h01);

    // Entering set mode while ringing returns to ARMED.
    start_ring("setr");
    bus.set_alarm = 1'b1;
    repeat (2) @(negedge clk);
    check("set_while_ring", int'(bus.state), 1);
    check("set_while_ring_r", int'(bus.ringing), 0);
    bus.set_alarm = 1'b0;
    @(negedge clk);

    // Reset mid-ring.
    start_ring("rst");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ringing", int'(bus.ringing), 0);
    check("midrst_buzzer", int'(bus.buzzer), 0);
    check("midrst_state", int'(bus.state), 0);
    check("midrst_alarm", alarm_word(), 16'h0700);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm stage directly downstream of the binary clock counter. It consumes the clock's BCD time digits and its 1 Hz square wave, holds a user-set alarm time in BCD, and raises a ringing/buzzer output when the time of day matches. It supports stop and timed snooze, and exports the stored alarm digits for the display path.

## Interface
Parameters:
- RING_SECONDS, 60, seconds of ringing before automatic return to ARMED
- SNOOZE_MINUTES, 5, snooze length in minutes
- ALARM_HR_INIT, 7, alarm hour after reset (binary 0..23)
- ALARM_MIN_INIT, 0, alarm minute after reset (binary 0..59)

Ports:
- clk_100MHz  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk_100MHz
- tick_1Hz  in  1  1 Hz square wave from the clock counter
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  current time, BCD
- set_alarm  in  1  level; 1 = alarm-set mode
- alarm_en  in  1  level switch; 0 disables the alarm
- btn_hr, btn_min, btn_snooze, btn_stop  in  1 each  raw push buttons, active-high
- alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  out  4 each  stored alarm time, BCD, registered
- ringing  out  1  1 while in RINGING
- snoozing  out  1  1 while in SNOOZE
- buzzer  out  1  audible drive: 1-s-on / 1-s-off pattern while ringing
- state  out  2  current FSM state (debug)

## Operation
- All inputs pass through a 2-flop synchronizer plus rising-edge detector; single-cycle pulses: sec_p, hr_p, min_p, snz_p, stop_p.
- Alarm set: while set_alarm=1, hr_p increments the alarm hour 23→00 wrap; min_p increments the minute 59→00 wrap, with no carry into the hour. hr_p and min_p in the same cycle both apply. Stored in BCD; each digit is updated with BCD-correct carry (x9→(x+1)0).
- Match: sec_p AND current hr/min == alarm hr/min AND sec_10s=0, sec_1s=0 AND set_alarm=0.
- FSM states: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
  - Any state, alarm_en=0 → IDLE. Ring/snooze counters cleared.
  - IDLE, alarm_en=1 → ARMED.
  - ARMED, match → RINGING: ring_ctr=0, beep=1.
  - RINGING: stop_p → ARMED. Otherwise snz_p → SNOOZE with snooze_ctr=SNOOZE_MINUTES*60. Stop wins over snooze. On each sec_p: ring_ctr+1 and beep toggles; when ring_ctr reaches RING_SECONDS-1, that sec_p → ARMED.
  - SNOOZE: stop_p → ARMED. On each sec_p: snooze_ctr-1; the sec_p that reaches 0 → RINGING with ring_ctr=0, beep=1.
  - RINGING or SNOOZE with set_alarm=1 → ARMED. Priority is alarm_en, then set_alarm, then stop, snooze and timers.
- ringing, snoozing, buzzer (=RINGING & beep) and state are registered decodes of the FSM.
- Counter widths: $clog2(RING_SECONDS+1) and $clog2(SNOOZE_MINUTES*60+1) bits.

## Timing
- Reset values: state=IDLE, ringing=0, snoozing=0, buzzer=0, alarm digits = ALARM_HR_INIT:ALARM_MIN_INIT in BCD (default 07:00), all synchronizer flops 0.
- Pulse latency: 3 clk_100MHz cycles after an input rising edge. Time digits are stable by then.
- FSM and alarm-digit updates take effect on the cycle after the pulse. Outputs follow in the same registered cycle.
- An input already high at reset release yields one edge pulse. This is accepted behaviour: the FSM ignores it in IDLE, but a button held through reset in set mode increments once.
- Reset mid-ring: ringing and buzzer drop on the first clock with reset=0.

## Structure
- Package alarm_pkg: state encodings, BCD limits (HR_MAX=23, MIN_MAX=59), and an increment-BCD-with-wrap function.
- Sub-module edge_sync (2-flop sync + rising-edge pulse), instantiated five times.
- Top holds the alarm BCD registers, the FSM and the ring/snooze counters.

## Test plan
- Reset, alarm_en=1, set_alarm=1, 3×btn_min and 18×btn_hr → alarm digits 01:03 (7+18=25 wraps to 01). btn_min from 59 → 00 with hour unchanged.
- Alarm 07:00, time stepped to 06:59:59 then 07:00:00 with a tick_1Hz rise → ringing=1 and buzzer=1 within 4 cycles. buzzer toggles on each of the next sec_p.
- RINGING with no buttons → ringing falls after 60 sec_p pulses, state=ARMED.
- RINGING, btn_snooze → snoozing=1. After 300 sec_p pulses → ringing=1 again. btn_stop in SNOOZE → ARMED.
- btn_snooze and btn_stop pressed in the same cycle while ringing → ARMED, snoozing stays 0.
- alarm_en dropped while ringing → IDLE next cycle, buzzer=0. A match with set_alarm=1 → no ring. reset=0 mid-ring → all outputs return to reset values.
